// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-outstanding load/store responder over an internal word array
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          access, acc_err;
    logic [AW-1:0] idx;

    assign idx     = addr_q[AW+1:2];
    assign acc_err = (addr_q[1:0] != 2'b0) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign access  = (state_q == WAIT) && (cnt_q == 4'd0);

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // next state: accept in IDLE, count down in WAIT, single-cycle RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                state_d = req_valid ? WAIT : IDLE;
                cnt_d   = req_valid ? 4'(LATENCY - 1) : cnt_q;
            end
            WAIT: begin
                state_d = (cnt_q == 4'd0) ? RESP : WAIT;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and latency counter; reset abandons any in-flight request
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // request capture on the acceptance edge; held stable through WAIT
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // memory access and response registers; reset wins over a coincident store
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || write_q) ? '0 : mem_q[idx];
            if (!acc_err && write_q)
                for (int b = 0; b < 4; b++)
                    if (be_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for LATENCY=2 and LATENCY=1 builds
module tb_dmem_responder;
    localparam int L0 = 2;
    localparam int P0 = L0 + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v0 = 0, w0 = 0, v1 = 0, w1 = 0;
    logic [31:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
    logic [3:0]  b0 = 0, b1 = 0;
    logic        rdy0, rv0, err0, bsy0, rdy1, rv1, err1, bsy1;
    logic [31:0] rd0, rd1;

    logic [32:0] sb [$];
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(L0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_write(w0),
        .req_addr(a0), .req_wdata(d0), .req_be(b0), .resp_valid(rv0),
        .resp_rdata(rd0), .resp_err(err0), .busy(bsy0)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1), .req_be(b1), .resp_valid(rv1),
        .resp_rdata(rd1), .resp_err(err1), .busy(bsy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input bit s, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_rd, input bit exp_err,
                          input string tag);
        int lat;
        int c;
        logic [32:0] e;
        lat = s ? 1 : L0;
        chk({tag, " ready_idle"}, s ? rdy1 : rdy0, 1);
        if (s) begin v1 = 1; w1 = wr; a1 = a; d1 = wd; b1 = be; end
        else   begin v0 = 1; w0 = wr; a0 = a; d0 = wd; b0 = be; end
        sb.push_back({exp_err, exp_rd});
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        chk({tag, " ready_wait"}, s ? rdy1 : rdy0, 0);
        chk({tag, " busy_wait"}, s ? bsy1 : bsy0, 1);
        c = 0;
        while (!(s ? rv1 : rv0) && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk({tag, " latency"}, 64'(c), 64'(lat));
        chk({tag, " resp_valid"}, s ? rv1 : rv0, 1);
        e = sb.pop_front();
        chk({tag, " resp"}, s ? {err1, rd1} : {err0, rd0}, e);
        chk({tag, " ready_resp"}, s ? rdy1 : rdy0, 0);
        @(posedge clk); #1;
        chk({tag, " resp_pulse"}, s ? rv1 : rv0, 0);
        chk({tag, " ready_back"}, s ? rdy1 : rdy0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        logic [32:0] e;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", {rdy0, rdy1}, 2'b11);
        chk("rst resp_valid", {rv0, rv1}, 2'b00);
        chk("rst busy", {bsy0, bsy1}, 2'b00);
        chk("rst resp", {err0, rd0, err1, rd1}, 66'd0);
        reset = 1;
        @(posedge clk); #1;

        do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, "st 0x10");
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, "ld 0x10");
        do_req(0, 1, 32'h20, 32'h11223344, 4'h5, 32'h0, 0, "st be5");
        do_req(0, 0, 32'h20, 32'h0, 4'hF, 32'h00220044, 0, "ld be5");
        do_req(0, 1, 32'h20, 32'hAABBCCDD, 4'hA, 32'h0, 0, "st beA");
        do_req(0, 0, 32'h20, 32'h0, 4'h0, 32'hAA22CC44, 0, "ld beA");
        do_req(0, 1, 32'h0, 32'h12345678, 4'hF, 32'h0, 0, "st w0");
        do_req(0, 0, 32'h13, 32'h0, 4'h0, 32'h0, 1, "ld misal");
        do_req(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1, "st oor");
        do_req(0, 1, 32'h80000000, 32'hFFFFFFFF, 4'hF, 32'h0, 1, "st oor_hi");
        do_req(0, 0, 32'h3FC, 32'h0, 4'h0, 32'h0, 0, "ld last");
        do_req(0, 0, 32'h0, 32'h0, 4'h0, 32'h12345678, 0, "ld w0");
        do_req(0, 1, 32'h10, 32'h0, 4'h0, 32'h0, 0, "st be0");
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, "ld be0");

        acc = 0;
        v0 = 1; w0 = 0; a0 = 32'h10;
        for (int i = 0; i < 3 * P0; i++) begin
            chk("b2b ready", rdy0, (i % P0) == 0);
            chk("b2b resp_valid", rv0, (i % P0) == P0 - 1);
            if (rdy0) begin
                sb.push_back({1'b0, 32'hDEADBEEF});
                acc++;
            end
            if (rv0 && sb.size() > 0) begin
                e = sb.pop_front();
                chk("b2b resp", {err0, rd0}, e);
            end
            @(posedge clk); #1;
        end
        v0 = 0;
        chk("b2b accepts", 64'(acc), 3);
        chk("b2b sb empty", 64'(sb.size()), 0);

        do_req(1, 1, 32'h4, 32'hCAFEF00D, 4'hF, 32'h0, 0, "l1 st");
        do_req(1, 0, 32'h4, 32'h0, 4'h0, 32'hCAFEF00D, 0, "l1 ld");
        do_req(1, 0, 32'h6, 32'h0, 4'h0, 32'h0, 1, "l1 misal");

        v0 = 1; w0 = 1; a0 = 32'h8; d0 = 32'h55AA55AA; b0 = 4'hF;
        @(posedge clk); #1;
        v0 = 0;
        chk("mid busy", bsy0, 1);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        chk("mid resp_valid", rv0, 0);
        chk("mid ready", rdy0, 1);
        chk("mid busy_after", bsy0, 0);
        chk("mid resp", {err0, rd0}, 33'd0);
        v0 = 1; w0 = 0; a0 = 32'h8;
        @(posedge clk); #1;
        chk("rst no accept", bsy0, 0);
        v0 = 0;
        reset = 1;
        for (int i = 0; i < L0 + 2; i++) begin
            @(posedge clk); #1;
            chk("post rst quiet", {rv0, bsy0}, 2'b00);
        end
        do_req(0, 0, 32'h8, 32'h0, 4'h0, 32'h0, 0, "ld 0x8");
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0, "ld cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
